// File: rtl/rom_ddr_pkg.sv
// Shared definitions for the cart-ROM DDRAM bridge.
//   state_t      : bridge FSM states
//   BASE_QW_DEF  : default DDRAM qword base of the ROM area (byte 0x06000000)
//   be_of()      : byte-enable pattern for a 16-bit lane inside a 64-bit qword
//   lane_of()    : extract 16-bit lane k from a 64-bit line
package rom_ddr_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR_CMD,
        S_RD_CMD,
        S_RD_WAIT
    } state_t;

    localparam logic [28:0] BASE_QW_DEF = 29'h00C00000;

    function automatic logic [7:0] be_of(input logic [1:0] lane);
        return 8'h03 << {lane, 1'b0};
    endfunction

    function automatic logic [15:0] lane_of(input logic [63:0] line, input logic [1:0] lane);
        return line[{lane, 4'b0000} +: 16];
    endfunction

endpackage

// File: rtl/rom_ddr_bridge.sv
// Responder for the cart-ROM toggle handshakes. Each 16-bit write from the
// loader and each 16-bit ROM fetch becomes one single-beat 64-bit DDRAM
// Avalon transaction; a one-line (8-byte) read cache short-circuits fetches
// that fall in the most recently loaded qword.
// Ports:
//   DDRAM_CLK, RESET          clock (rising edge), async active-high reset
//   wraddr/din/we_req/we_ack  write side: byte address, data, toggle handshake
//   rdaddr/rd_req/rd_ack/dout read side: word address, toggle handshake, data
//   DDRAM_*                   Avalon master towards DDRAM
module rom_ddr_bridge
    import rom_ddr_pkg::*;
#(
    parameter logic [28:0] BASE_QW = BASE_QW_DEF,
    parameter int unsigned AW_BYTE = 25
) (
    input  logic               DDRAM_CLK,
    input  logic               RESET,
    input  logic [AW_BYTE-1:0] wraddr,
    input  logic [15:0]        din,
    input  logic               we_req,
    output logic               we_ack,
    input  logic [21:0]        rdaddr,
    input  logic               rd_req,
    output logic               rd_ack,
    output logic [15:0]        dout,
    input  logic               DDRAM_BUSY,
    output logic [7:0]         DDRAM_BURSTCNT,
    output logic [28:0]        DDRAM_ADDR,
    output logic               DDRAM_RD,
    output logic               DDRAM_WE,
    output logic [63:0]        DDRAM_DIN,
    output logic [7:0]         DDRAM_BE,
    input  logic [63:0]        DDRAM_DOUT,
    input  logic               DDRAM_DOUT_READY
);

    localparam int unsigned QW = AW_BYTE - 3;

    state_t        state_q, state_d;
    logic          we_ack_q, we_ack_d;
    logic          rd_ack_q, rd_ack_d;
    logic [15:0]   dout_q, dout_d;
    logic          rd_q, rd_d;
    logic          we_q, we_d;
    logic [QW-1:0] qaddr_q, qaddr_d;
    logic [1:0]    lane_q, lane_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [63:0]   line_q, line_d;
    logic [19:0]   tag_q, tag_d;
    logic          valid_q, valid_d;

    logic wr_pend, rd_pend, hit;

    // Word granularity: the low byte-address bit carries no information.
    logic unused_wraddr_bit0;
    assign unused_wraddr_bit0 = wraddr[0];

    assign wr_pend = we_req ^ we_ack_q;
    assign rd_pend = rd_req ^ rd_ack_q;
    assign hit     = valid_q && (tag_q == rdaddr[21:2]);

    always_ff @(posedge DDRAM_CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            we_ack_q <= 1'b0;
            rd_ack_q <= 1'b0;
            dout_q   <= '0;
            rd_q     <= 1'b0;
            we_q     <= 1'b0;
            qaddr_q  <= '0;
            lane_q   <= '0;
            wdata_q  <= '0;
            line_q   <= '0;
            tag_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_ack_q <= we_ack_d;
            rd_ack_q <= rd_ack_d;
            dout_q   <= dout_d;
            rd_q     <= rd_d;
            we_q     <= we_d;
            qaddr_q  <= qaddr_d;
            lane_q   <= lane_d;
            wdata_q  <= wdata_d;
            line_q   <= line_d;
            tag_q    <= tag_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        we_ack_d = we_ack_q;
        rd_ack_d = rd_ack_q;
        dout_d   = dout_q;
        rd_d     = rd_q;
        we_d     = we_q;
        qaddr_d  = qaddr_q;
        lane_d   = lane_q;
        wdata_d  = wdata_q;
        line_d   = line_q;
        tag_d    = tag_q;
        valid_d  = valid_q;

        case (state_q)
            S_IDLE: begin
                if (wr_pend) begin
                    qaddr_d = wraddr[AW_BYTE-1:3];
                    lane_d  = wraddr[2:1];
                    wdata_d = din;
                    we_d    = 1'b1;
                    state_d = S_WR_CMD;
                end else if (rd_pend) begin
                    if (hit) begin
                        dout_d   = lane_of(line_q, rdaddr[1:0]);
                        rd_ack_d = ~rd_ack_q;
                    end else begin
                        qaddr_d = QW'(rdaddr[21:2]);
                        lane_d  = rdaddr[1:0];
                        rd_d    = 1'b1;
                        state_d = S_RD_CMD;
                    end
                end
            end
            S_WR_CMD: begin
                if (!DDRAM_BUSY) begin
                    we_d     = 1'b0;
                    we_ack_d = ~we_ack_q;
                    // Cached lines only span byte addresses below 8 MiB, so
                    // the tag is zero-extended before comparing.
                    if (valid_q && (qaddr_q == QW'(tag_q))) begin
                        line_d[{lane_q, 4'b0000} +: 16] = wdata_q;
                    end
                    state_d = S_IDLE;
                end
            end
            S_RD_CMD: begin
                if (!DDRAM_BUSY) begin
                    rd_d    = 1'b0;
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (DDRAM_DOUT_READY) begin
                    line_d   = DDRAM_DOUT;
                    tag_d    = qaddr_q[19:0];
                    valid_d  = 1'b1;
                    dout_d   = lane_of(DDRAM_DOUT, lane_q);
                    rd_ack_d = ~rd_ack_q;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign we_ack         = we_ack_q;
    assign rd_ack         = rd_ack_q;
    assign dout           = dout_q;
    assign DDRAM_BURSTCNT = 8'd1;
    assign DDRAM_ADDR     = BASE_QW + 29'(qaddr_q);
    assign DDRAM_RD       = rd_q;
    assign DDRAM_WE       = we_q;
    assign DDRAM_DIN      = {4{wdata_q}};
    assign DDRAM_BE       = be_of(lane_q);

endmodule

// File: tb/tb_rom_ddr_bridge.sv
module tb_rom_ddr_bridge;

    logic        clk = 1'b0;
    logic        RESET;
    logic [24:0] wraddr;
    logic [15:0] din;
    logic        we_req;
    logic        we_ack;
    logic [21:0] rdaddr;
    logic        rd_req;
    logic        rd_ack;
    logic [15:0] dout;
    logic        DDRAM_BUSY;
    logic [7:0]  DDRAM_BURSTCNT;
    logic [28:0] DDRAM_ADDR;
    logic        DDRAM_RD;
    logic        DDRAM_WE;
    logic [63:0] DDRAM_DIN;
    logic [7:0]  DDRAM_BE;
    logic [63:0] DDRAM_DOUT;
    logic        DDRAM_DOUT_READY;

    always #5 clk = ~clk;

    rom_ddr_bridge #(.BASE_QW(29'h00C00000), .AW_BYTE(25)) dut (
        .DDRAM_CLK        (clk),
        .RESET            (RESET),
        .wraddr           (wraddr),
        .din              (din),
        .we_req           (we_req),
        .we_ack           (we_ack),
        .rdaddr           (rdaddr),
        .rd_req           (rd_req),
        .rd_ack           (rd_ack),
        .dout             (dout),
        .DDRAM_BUSY       (DDRAM_BUSY),
        .DDRAM_BURSTCNT   (DDRAM_BURSTCNT),
        .DDRAM_ADDR       (DDRAM_ADDR),
        .DDRAM_RD         (DDRAM_RD),
        .DDRAM_WE         (DDRAM_WE),
        .DDRAM_DIN        (DDRAM_DIN),
        .DDRAM_BE         (DDRAM_BE),
        .DDRAM_DOUT       (DDRAM_DOUT),
        .DDRAM_DOUT_READY (DDRAM_DOUT_READY)
    );

    typedef struct {
        logic        wr;
        logic [28:0] addr;
        logic [7:0]  be;
        logic [63:0] din;
        int unsigned len;
    } cmd_t;

    cmd_t        exp_cmd[$];
    logic [15:0] exp_rd[$];
    int          exp_wr_cnt = 0;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    // Monitor: samples 1 time unit after each rising edge.
    logic        in_cmd = 1'b0;
    int unsigned cur_len, want_len;
    logic [28:0] cap_addr;
    logic        cap_we;
    logic        stable_bad;
    logic        overlap_seen = 1'b0;
    logic        prev_rd_ack = 1'b0;
    logic        prev_we_ack = 1'b0;

    always @(posedge clk) begin
        #1;
        if (RESET) begin
            in_cmd      = 1'b0;
            prev_rd_ack = rd_ack;
            prev_we_ack = we_ack;
        end else begin
            if (DDRAM_RD && DDRAM_WE) overlap_seen = 1'b1;
            if ((DDRAM_RD || DDRAM_WE) && !in_cmd) begin
                in_cmd     = 1'b1;
                cur_len    = 1;
                cap_addr   = DDRAM_ADDR;
                cap_we     = DDRAM_WE;
                stable_bad = 1'b0;
                if (exp_cmd.size() == 0) begin
                    chk("cmd_unexpected", 1, 0);
                    want_len = 0;
                end else begin
                    cmd_t c;
                    c = exp_cmd.pop_front();
                    want_len = c.len;
                    chk("cmd_type_we", DDRAM_WE, c.wr);
                    chk("cmd_addr", DDRAM_ADDR, c.addr);
                    if (c.wr) begin
                        chk("cmd_be", DDRAM_BE, c.be);
                        chk("cmd_din", DDRAM_DIN, c.din);
                    end
                end
            end else if ((DDRAM_RD || DDRAM_WE) && in_cmd) begin
                cur_len++;
                if (DDRAM_ADDR != cap_addr || DDRAM_WE != cap_we) stable_bad = 1'b1;
            end else if (in_cmd) begin
                in_cmd = 1'b0;
                chk("cmd_len", cur_len, want_len);
                chk("cmd_stable", stable_bad, 0);
            end

            if (rd_ack != prev_rd_ack) begin
                if (exp_rd.size() == 0) begin
                    chk("rd_ack_unexpected", 1, 0);
                end else begin
                    chk("rd_dout", dout, exp_rd.pop_front());
                    chk("rd_ack_eq_req", rd_ack, rd_req);
                end
            end
            if (we_ack != prev_we_ack) begin
                if (exp_wr_cnt == 0) begin
                    chk("we_ack_unexpected", 1, 0);
                end else begin
                    exp_wr_cnt--;
                    chk("we_ack_eq_req", we_ack, we_req);
                end
            end
            prev_rd_ack = rd_ack;
            prev_we_ack = we_ack;
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 100 && (we_ack != we_req || rd_ack != rd_req); i++) @(negedge clk);
        if (we_ack != we_req || rd_ack != rd_req) chk("idle_timeout", 1, 0);
        @(negedge clk);
    endtask

    task automatic wait_rd(input logic level);
        for (int i = 0; i < 50 && DDRAM_RD != level; i++) @(negedge clk);
        if (DDRAM_RD != level) chk("rd_strobe_timeout", DDRAM_RD, level);
    endtask

    task automatic do_write(input logic [24:0] a, input logic [15:0] d, input int unsigned busy,
                            input logic [28:0] e_addr, input logic [7:0] e_be);
        cmd_t c;
        @(negedge clk);
        c.wr = 1'b1; c.addr = e_addr; c.be = e_be; c.din = {4{d}}; c.len = busy + 1;
        exp_cmd.push_back(c);
        exp_wr_cnt++;
        wraddr = a;
        din    = d;
        if (busy > 0) DDRAM_BUSY = 1'b1;
        we_req = ~we_req;
        repeat (busy + 1) @(negedge clk);
        DDRAM_BUSY = 1'b0;
        wait_idle();
    endtask

    task automatic do_read(input logic [21:0] w, input logic miss, input logic [28:0] e_addr,
                           input logic [63:0] line, input logic [15:0] e_dout);
        cmd_t c;
        @(negedge clk);
        if (miss) begin
            c.wr = 1'b0; c.addr = e_addr; c.be = '0; c.din = '0; c.len = 1;
            exp_cmd.push_back(c);
        end
        exp_rd.push_back(e_dout);
        rdaddr = w;
        rd_req = ~rd_req;
        @(negedge clk);
        if (miss) begin
            chk("miss_rd_next_edge", DDRAM_RD, 1);
            wait_rd(1'b0);
            DDRAM_DOUT       = line;
            DDRAM_DOUT_READY = 1'b1;
            @(negedge clk);
            DDRAM_DOUT_READY = 1'b0;
            chk("miss_ack_on_ready", rd_ack, rd_req);
        end else begin
            chk("hit_ack_one_edge", rd_ack, rd_req);
        end
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1;
        wraddr = '0; din = '0; we_req = 1'b0;
        rdaddr = '0; rd_req = 1'b0;
        DDRAM_BUSY = 1'b0; DDRAM_DOUT = '0; DDRAM_DOUT_READY = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_we_ack", we_ack, 0);
        chk("rst_rd_ack", rd_ack, 0);
        chk("rst_dout", dout, 0);
        chk("rst_rd", DDRAM_RD, 0);
        chk("rst_we", DDRAM_WE, 0);
        chk("burstcnt", DDRAM_BURSTCNT, 8'd1);
        RESET = 1'b0;
        repeat (2) @(negedge clk);

        // Write to byte 0x6 -> qword 0, lane 3.
        do_write(25'h000006, 16'hBEEF, 0, 29'h0C00000, 8'hC0);

        // Read byte 0x4 (word 2): miss, lane 2; then byte 0x6 (word 3): hit.
        do_read(22'h000002, 1'b1, 29'h0C00000, 64'h4444_3333_2222_1111, 16'h3333);
        do_read(22'h000003, 1'b0, 29'h0, 64'h0, 16'h4444);

        // Write stalled by BUSY for 5 edges: strobe held 6 cycles.
        do_write(25'h000100, 16'h1234, 5, 29'h0C00020, 8'h03);

        // Top of the byte address range: qword 0x3FFFFF.
        do_write(25'h1FFFFFE, 16'h5A5A, 0, 29'h0FFFFFF, 8'hC0);

        // Simultaneous write to byte 0x2 and read of word 1 in the cached line.
        begin
            cmd_t c;
            @(negedge clk);
            c.wr = 1'b1; c.addr = 29'h0C00000; c.be = 8'h0C; c.din = {4{16'hCAFE}}; c.len = 1;
            exp_cmd.push_back(c);
            exp_wr_cnt++;
            exp_rd.push_back(16'hCAFE);
            wraddr = 25'h000002; din = 16'hCAFE; rdaddr = 22'h000001;
            we_req = ~we_req;
            rd_req = ~rd_req;
            @(negedge clk);
            chk("prio_we_first", DDRAM_WE, 1);
            chk("prio_rd_pending", rd_ack ^ rd_req, 1);
            wait_idle();
        end
        do_read(22'h000000, 1'b0, 29'h0, 64'h0, 16'h1111);
        do_read(22'h000003, 1'b0, 29'h0, 64'h0, 16'h4444);
        do_read(22'h000001, 1'b0, 29'h0, 64'h0, 16'hCAFE);

        // Reset while waiting for read data, then a stray DOUT_READY.
        begin
            cmd_t c;
            @(negedge clk);
            c.wr = 1'b0; c.addr = 29'h0C00040; c.be = '0; c.din = '0; c.len = 1;
            exp_cmd.push_back(c);
            exp_rd.push_back(16'hFFFF);
            rdaddr = 22'h000100;
            rd_req = ~rd_req;
            wait_rd(1'b1);
            wait_rd(1'b0);
            @(negedge clk);
            RESET  = 1'b1;
            rd_req = 1'b0;
            we_req = 1'b0;
            exp_rd.delete();
            repeat (2) @(negedge clk);
            RESET = 1'b0;
            chk("rst2_rd_ack", rd_ack, 0);
            chk("rst2_we_ack", we_ack, 0);
            chk("rst2_dout", dout, 0);
            chk("rst2_rd", DDRAM_RD, 0);
            @(negedge clk);
            DDRAM_DOUT       = 64'h9999_8888_7777_6666;
            DDRAM_DOUT_READY = 1'b1;
            @(negedge clk);
            DDRAM_DOUT_READY = 1'b0;
            repeat (2) @(negedge clk);
            chk("stray_ready_rd_ack", rd_ack, 0);
            chk("stray_ready_dout", dout, 0);
        end
        // Line 0 was cached before the reset; it must be fetched again.
        do_read(22'h000000, 1'b1, 29'h0C00000, 64'hDDDD_CCCC_BBBB_AAAA, 16'hAAAA);

        repeat (4) @(negedge clk);
        chk("cmd_queue_drained", exp_cmd.size(), 0);
        chk("rd_queue_drained", exp_rd.size(), 0);
        chk("wr_acks_drained", exp_wr_cnt, 0);
        chk("rd_we_exclusive", overlap_seen, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
